spi_txn_sequencer: RTL and testbench

Transaction sequencer for the SPI memory slave. Consumes conditioned CS level and SCLK edge pulses, counts bits, decodes the command byte, owns the 7-bit memory address register, and drives shift-register mode, data-memory write enable and MISO buffer enable. Sits between the input conditioners and the shift-register/data-memory datapath, which it replaces the address latch of.

---
 rtl/spi_txn_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_spi_txn_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_txn_sequencer
// Brief    : SPI memory-slave transaction sequencer. Counts SCLK edges,
//            decodes the command byte (addr[7:1], R/W[0]), owns the memory
//            address register and drives shift-register mode, data-memory
//            write enable and MISO buffer enable.
// Options  : SPI_BURST_EN - when defined, the sequencer keeps streaming
//            data bytes with an auto-incrementing (wrapping) address while
//            cs_n stays low; otherwise one data byte per CS assertion.
// Revision : 1.0 - initial release
// ============================================================================
module spi_txn_sequencer #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              sclk_posedge,
    input  logic [DATA_W-1:0] sr_pout,
    output logic [1:0]        sr_mode,
    output logic              dm_we,
    output logic              miso_buf_e,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              overrun
);

    localparam int               c_cnt_w    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);

    localparam logic [1:0] c_mode_hold  = 2'b00;
    localparam logic [1:0] c_mode_shift = 2'b01;
    localparam logic [1:0] c_mode_load  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_GET_CMD      = 3'd1,
        S_DECODE       = 3'd2,
        S_READ_LOAD    = 3'd3,
        S_READ_SHIFT   = 3'd4,
        S_WRITE_SHIFT  = 3'd5,
        S_WRITE_COMMIT = 3'd6,
        S_DONE         = 3'd7
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_bit_cnt;

    // Single-cycle states cannot consume an SCLK edge; one arriving there is lost.
    logic w_edge_dropped;
    assign w_edge_dropped = sclk_posedge &&
                            ((r_state == S_DECODE) ||
                             (r_state == S_READ_LOAD) ||
                             (r_state == S_WRITE_COMMIT));

    // Transaction FSM: all outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            sr_mode    <= c_mode_hold;
            dm_we      <= 1'b0;
            miso_buf_e <= 1'b0;
            addr       <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            dm_we <= 1'b0;

            if (w_edge_dropped) begin
                overrun <= 1'b1;
            end

            if (cs_n && (r_state != S_IDLE)) begin
                // Deselect aborts anything in flight; a partial byte is never committed.
                r_state    <= S_IDLE;
                r_bit_cnt  <= '0;
                sr_mode    <= c_mode_hold;
                miso_buf_e <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!cs_n) begin
                            r_state   <= S_GET_CMD;
                            r_bit_cnt <= '0;
                            overrun   <= 1'b0;
                            busy      <= 1'b1;
                            sr_mode   <= c_mode_shift;
                        end
                    end

                    S_GET_CMD: begin
                        if (sclk_posedge) begin
                            if (r_bit_cnt == c_last_bit) begin
                                r_state   <= S_DECODE;
                                r_bit_cnt <= '0;
                                sr_mode   <= c_mode_hold;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
                            end
                        end
                    end

                    S_DECODE: begin
                        addr <= sr_pout[ADDR_W:1];
                        if (sr_pout[0]) begin
                            r_state    <= S_READ_LOAD;
                            sr_mode    <= c_mode_load;
                            miso_buf_e <= 1'b1;
                        end else begin
                            r_state <= S_WRITE_SHIFT;
                            sr_mode <= c_mode_shift;
                        end
                    end

                    S_READ_LOAD: begin
                        r_state <= S_READ_SHIFT;
                        sr_mode <= c_mode_shift;
                    end

                    S_READ_SHIFT: begin
                        if (sclk_posedge) begin
                            if (r_bit_cnt == c_last_bit) begin
                                r_bit_cnt <= '0;
`ifdef SPI_BURST_EN
                                addr    <= addr + ADDR_W'(1);
                                r_state <= S_READ_LOAD;
                                sr_mode <= c_mode_load;
`else
                                r_state    <= S_DONE;
                                sr_mode    <= c_mode_hold;
                                miso_buf_e <= 1'b0;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
                            end
                        end
                    end

                    S_WRITE_SHIFT: begin
                        if (sclk_posedge) begin
                            if (r_bit_cnt == c_last_bit) begin
                                r_bit_cnt <= '0;
                                r_state   <= S_WRITE_COMMIT;
                                sr_mode   <= c_mode_hold;
                                dm_we     <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
                            end
                        end
                    end

                    S_WRITE_COMMIT: begin
                        // addr only moves after the write pulse so the commit sees a stable address.
`ifdef SPI_BURST_EN
                        addr    <= addr + ADDR_W'(1);
                        r_state <= S_WRITE_SHIFT;
                        sr_mode <= c_mode_shift;
`else
                        r_state <= S_DONE;
                        sr_mode <= c_mode_hold;
`endif
                    end

                    S_DONE: begin
                        sr_mode    <= c_mode_hold;
                        miso_buf_e <= 1'b0;
                    end

                    default: begin
                        r_state    <= S_IDLE;
                        r_bit_cnt  <= '0;
                        sr_mode    <= c_mode_hold;
                        miso_buf_e <= 1'b0;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_txn_sequencer
// Brief    : Self-checking bench for spi_txn_sequencer. Models the shift
//            register and data memory around the sequencer; expected writes
//            and read loads are queued by the stimulus and popped by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_txn_sequencer;

`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cs_n;
    logic       sclk_posedge;
    logic       mosi;
    logic [7:0] sr_pout;
    logic [1:0] sr_mode;
    logic       dm_we;
    logic       miso_buf_e;
    logic [6:0] addr;
    logic       busy;
    logic       overrun;

    logic [7:0] sr;
    logic [7:0] mem [0:127];

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;
    int we_count = 0;

    spi_txn_sequencer #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .cs_n         (cs_n),
        .sclk_posedge (sclk_posedge),
        .sr_pout      (sr_pout),
        .sr_mode      (sr_mode),
        .dm_we        (dm_we),
        .miso_buf_e   (miso_buf_e),
        .addr         (addr),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    assign sr_pout = sr;

    // Datapath model: shift register and data memory driven by the sequencer.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= 8'h00;
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
        end else begin
            if (sr_mode == 2'b01 && sclk_posedge) sr <= {sr[6:0], mosi};
            else if (sr_mode == 2'b10)           sr <= mem[addr];
            if (dm_we) mem[addr] <= sr;
        end
    end

    // Scoreboard monitor: every write pulse and every parallel load must be expected.
    always @(negedge clk) begin
        if (!reset && dm_we === 1'b1) begin
            we_count++;
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL dm_we_unexpected: got write addr=%0d data=%h, required no write", addr, sr);
            end else begin
                mon_e = wq.pop_front();
                if (addr !== mon_e.a || sr !== mon_e.d) begin
                    failures++;
                    $display("FAIL dm_we_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             addr, sr, mon_e.a, mon_e.d);
                end
            end
        end
        if (!reset && sr_mode === 2'b10) begin
            checks++;
            if (rq.size() == 0) begin
                failures++;
                $display("FAIL read_load_unexpected: got load addr=%0d, required no load", addr);
            end else begin
                mon_e = rq.pop_front();
                if (addr !== mon_e.a || mem[addr] !== mon_e.d) begin
                    failures++;
                    $display("FAIL read_load: got addr=%0d data=%h, required addr=%0d data=%h",
                             addr, mem[addr], mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the top n bits of b MSB-first, 4 clk per edge; returns at the
    // negedge of the cycle after the last edge. Captures MISO (sr MSB).
    task automatic send_bits(input logic [7:0] b, input int n,
                             output logic [7:0] miso_bits, output int en_cnt);
        miso_bits = 8'h00;
        en_cnt    = 0;
        for (int i = 7; i > 7 - n; i--) begin
            repeat (3) @(negedge clk);
            mosi         = b[i];
            sclk_posedge = 1'b1;
            miso_bits    = {miso_bits[6:0], sr[7]};
            if (miso_buf_e === 1'b1) en_cnt++;
            @(negedge clk);
            sclk_posedge = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cs_n = 1'b1; sclk_posedge = 1'b0; mosi = 1'b0;
        tick(3);
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: got busy=%b overrun=%b, required 0 0", busy, overrun);
        end
        checks++;
        if (sr_mode !== 2'b00 || dm_we !== 1'b0 || miso_buf_e !== 1'b0) begin
            failures++;
            $display("FAIL reset_enables: got sr_mode=%b dm_we=%b miso=%b, required 00 0 0", sr_mode, dm_we, miso_buf_e);
        end
        checks++;
        if (addr !== 7'd0) begin
            failures++;
            $display("FAIL reset_addr: got %0d, required 0", addr);
        end
        reset = 1'b0;
        tick(2);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_cs_high: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_write();
        logic [7:0] mb;
        int         en;
        cs_n = 1'b0;
        tick(1);
        checks++;
        if (busy !== 1'b1 || sr_mode !== 2'b01) begin
            failures++;
            $display("FAIL cs_fall: got busy=%b sr_mode=%b, required 1 01", busy, sr_mode);
        end
        send_bits(8'h0A, 8, mb, en);
        tick(1);
        checks++;
        if (addr !== 7'd5 || sr_mode !== 2'b01) begin
            failures++;
            $display("FAIL write_decode: got addr=%0d sr_mode=%b, required 5 01", addr, sr_mode);
        end
        wq.push_back('{7'd5, 8'h3C});
        send_bits(8'h3C, 8, mb, en);
        checks++;
        if (dm_we !== 1'b1 || addr !== 7'd5) begin
            failures++;
            $display("FAIL write_pulse: got dm_we=%b addr=%0d, required 1 5", dm_we, addr);
        end
        tick(1);
        checks++;
        if (dm_we !== 1'b0) begin
            failures++;
            $display("FAIL write_pulse_width: got dm_we=%b, required 0", dm_we);
        end
        cs_n = 1'b1;
        tick(1);
        checks++;
        if (busy !== 1'b0 || sr_mode !== 2'b00) begin
            failures++;
            $display("FAIL write_cs_rise: got busy=%b sr_mode=%b, required 0 00", busy, sr_mode);
        end
        tick(2);
    endtask

    task automatic test_read();
        logic [7:0] mb;
        int         en;
        cs_n = 1'b0;
        rq.push_back('{7'd5, 8'h3C});
        if (BURST) rq.push_back('{7'd6, 8'h00});
        send_bits(8'h0B, 8, mb, en);
        checks++;
        if (busy !== 1'b1 || miso_buf_e !== 1'b0) begin
            failures++;
            $display("FAIL read_decode: got busy=%b miso=%b, required 1 0", busy, miso_buf_e);
        end
        tick(1);
        checks++;
        if (sr_mode !== 2'b10 || miso_buf_e !== 1'b1 || addr !== 7'd5) begin
            failures++;
            $display("FAIL read_load_timing: got sr_mode=%b miso=%b addr=%0d, required 10 1 5", sr_mode, miso_buf_e, addr);
        end
        send_bits(8'h00, 8, mb, en);
        checks++;
        if (mb !== 8'h3C) begin
            failures++;
            $display("FAIL read_data: got %h, required 3c", mb);
        end
        checks++;
        if (en !== 8) begin
            failures++;
            $display("FAIL read_miso_en: got %0d edges enabled, required 8", en);
        end
        checks++;
        if (miso_buf_e !== BURST) begin
            failures++;
            $display("FAIL read_end: got miso=%b, required %b", miso_buf_e, BURST);
        end
        cs_n = 1'b1;
        tick(1);
        checks++;
        if (busy !== 1'b0 || miso_buf_e !== 1'b0 || sr_mode !== 2'b00) begin
            failures++;
            $display("FAIL read_cs_rise: got busy=%b miso=%b sr_mode=%b, required 0 0 00", busy, miso_buf_e, sr_mode);
        end
        tick(2);
    endtask

    task automatic test_cs_abort();
        logic [7:0] mb;
        int         en;
        int         we_before;
        we_before = we_count;
        cs_n = 1'b0;
        send_bits(8'h12, 8, mb, en);
        send_bits(8'hFF, 4, mb, en);
        cs_n = 1'b1;
        tick(1);
        checks++;
        if (busy !== 1'b0 || sr_mode !== 2'b00 || dm_we !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got busy=%b sr_mode=%b dm_we=%b, required 0 00 0", busy, sr_mode, dm_we);
        end
        tick(4);
        checks++;
        if (we_count !== we_before) begin
            failures++;
            $display("FAIL abort_no_write: got %0d write pulses, required 0", we_count - we_before);
        end
        checks++;
        if (mem[9] !== 8'h00) begin
            failures++;
            $display("FAIL abort_mem: got mem[9]=%h, required 00", mem[9]);
        end
    endtask

    task automatic test_burst();
        logic [7:0] mb;
        int         en;
        int         we_before;
        we_before = we_count;
        wq.push_back('{7'd127, 8'h11});
        if (BURST) begin
            wq.push_back('{7'd0, 8'h22});
            wq.push_back('{7'd1, 8'h33});
        end
        cs_n = 1'b0;
        send_bits(8'hFE, 8, mb, en);
        send_bits(8'h11, 8, mb, en);
        send_bits(8'h22, 8, mb, en);
        send_bits(8'h33, 8, mb, en);
        cs_n = 1'b1;
        tick(2);
        checks++;
        if (we_count - we_before !== (BURST ? 3 : 1)) begin
            failures++;
            $display("FAIL burst_count: got %0d write pulses, required %0d", we_count - we_before, BURST ? 3 : 1);
        end
        checks++;
        if (mem[127] !== 8'h11) begin
            failures++;
            $display("FAIL burst_mem127: got %h, required 11", mem[127]);
        end
        checks++;
        if (mem[0] !== (BURST ? 8'h22 : 8'h00)) begin
            failures++;
            $display("FAIL burst_wrap: got mem[0]=%h, required %h", mem[0], BURST ? 8'h22 : 8'h00);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] mb;
        int         en;
        rq.push_back('{7'd5, 8'h3C});
        cs_n = 1'b0;
        send_bits(8'h0B, 7, mb, en);
        repeat (3) @(negedge clk);
        mosi         = 1'b1;
        sclk_posedge = 1'b1;
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_early: got %b, required 0", overrun);
        end
        @(negedge clk);
        sclk_posedge = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: got %b, required 1", overrun);
        end
        tick(3);
        cs_n = 1'b1;
        tick(2);
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL overrun_sticky: got overrun=%b busy=%b, required 1 0", overrun, busy);
        end
        cs_n = 1'b0;
        tick(1);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: got %b, required 0", overrun);
        end
        cs_n = 1'b1;
        tick(2);
    endtask

    task automatic test_reset_mid();
        logic [7:0] mb;
        int         en;
        cs_n = 1'b0;
        send_bits(8'hA0, 3, mb, en);
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || sr_mode !== 2'b00 || miso_buf_e !== 1'b0 || dm_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_enables: got busy=%b sr_mode=%b miso=%b dm_we=%b, required 0 00 0 0",
                     busy, sr_mode, miso_buf_e, dm_we);
        end
        checks++;
        if (addr !== 7'd0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_addr: got addr=%0d overrun=%b, required 0 0", addr, overrun);
        end
        @(negedge clk);
        cs_n  = 1'b1;
        reset = 1'b0;
        tick(2);
    endtask

    // Run bound: a stuck run reports and stops rather than hanging.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_cs_abort();
        test_burst();
        test_overrun();
        test_reset_mid();
        checks++;
        if (wq.size() != 0 || rq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d writes and %0d loads outstanding, required 0 0", wq.size(), rq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
